// File: rtl/ac_loop_controller.sv
// Closed-loop initiator for the AirConditioning block: feeds each returned
// out_temp back as the next temp until the setpoint, a stall, or a step limit.
module ac_loop_controller #(
    parameter int unsigned AC_LATENCY  = 1,
    parameter int unsigned MAX_STEPS   = 64,
    parameter int unsigned STALL_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] room_temp,
    input  logic [5:0] ideal,
    input  logic [5:0] ac_out_temp,
    output logic [5:0] ac_temp,
    output logic [5:0] ac_ideal,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       fault,
    output logic [7:0] step_count,
    output logic [5:0] final_temp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE,
        S_TIMEOUT,
        S_FAULT
    } state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(AC_LATENCY - 1);
    localparam logic [7:0] STEP_MAX  = 8'(MAX_STEPS);
    localparam logic [3:0] STALL_MAX = 4'(STALL_LIMIT);

    state_t     state, state_n;
    logic [1:0] wait_cnt, wait_n;
    logic [3:0] stall_cnt, stall_n, stall_inc;
    logic [5:0] temp_n, ideal_n, final_n;
    logic [7:0] step_n, step_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            stall_cnt  <= '0;
            ac_temp    <= '0;
            ac_ideal   <= '0;
            final_temp <= '0;
            step_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_n;
            stall_cnt  <= stall_n;
            ac_temp    <= temp_n;
            ac_ideal   <= ideal_n;
            final_temp <= final_n;
            step_count <= step_n;
            // Flags are decoded from the next state so they line up with it.
            busy       <= (state_n == S_WAIT) || (state_n == S_SAMPLE);
            done       <= (state_n == S_DONE);
            timeout    <= (state_n == S_TIMEOUT);
            fault      <= (state_n == S_FAULT);
        end
    end

    always_comb begin
        state_n   = state;
        wait_n    = wait_cnt;
        stall_n   = stall_cnt;
        temp_n    = ac_temp;
        ideal_n   = ac_ideal;
        final_n   = final_temp;
        step_n    = step_count;
        step_inc  = (step_count == 8'hFF) ? step_count : step_count + 8'd1;
        stall_inc = stall_cnt + 4'd1;

        case (state)
            S_IDLE: begin
                if (start) begin
                    temp_n  = room_temp;
                    ideal_n = ideal;
                    step_n  = '0;
                    stall_n = '0;
                    wait_n  = WAIT_LOAD;
                    if (room_temp == ideal) begin
                        final_n = room_temp;
                        state_n = S_DONE;
                    end else begin
                        final_n = '0;
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_n = S_SAMPLE;
                end else begin
                    wait_n = wait_cnt - 2'd1;
                end
            end
            S_SAMPLE: begin
                final_n = ac_out_temp;
                step_n  = step_inc;
                if (ac_out_temp == ac_ideal) begin
                    state_n = S_DONE;
                end else if ((ac_out_temp == ac_temp) && (stall_inc == STALL_MAX)) begin
                    stall_n = stall_inc;
                    state_n = S_FAULT;
                end else if (step_inc == STEP_MAX) begin
                    state_n = S_TIMEOUT;
                end else begin
                    // A non-terminal stall keeps counting; any progress clears it.
                    temp_n  = ac_out_temp;
                    stall_n = (ac_out_temp == ac_temp) ? stall_inc : '0;
                    wait_n  = WAIT_LOAD;
                    state_n = S_WAIT;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ac_loop_controller.sv
// Randomised and directed bench for ac_loop_controller against an in-bench
// run-level model of the feedback loop and a latency-accurate AC stand-in.
module tb_ac_loop_controller;

    localparam int unsigned LAT   = 2;
    localparam int unsigned MAXS  = 12;
    localparam int unsigned STALL = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] room_temp = '0;
    logic [5:0] ideal = '0;
    logic [5:0] ac_out_temp;
    logic [5:0] ac_temp, ac_ideal, final_temp;
    logic       busy, done, timeout, fault;
    logic [7:0] step_count;

    int checks = 0;
    int errors = 0;
    int mode = 0;  // 0: +1 per step, 1: frozen, 2: randomised

    always #5 clk = ~clk;

    ac_loop_controller #(
        .AC_LATENCY (LAT),
        .MAX_STEPS  (MAXS),
        .STALL_LIMIT(STALL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .room_temp  (room_temp),
        .ideal      (ideal),
        .ac_out_temp(ac_out_temp),
        .ac_temp    (ac_temp),
        .ac_ideal   (ac_ideal),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .fault      (fault),
        .step_count (step_count),
        .final_temp (final_temp)
    );

    // AirConditioning stand-in: response appears LAT cycles after temp changes.
    logic [5:0] pipe [LAT];

    function automatic logic [5:0] ac_next(input logic [5:0] t, input logic [5:0] sp, input int m);
        int r;
        if (m == 0) return t + 6'd1;
        if (m == 1) return t;
        r = $urandom_range(0, 9);
        if (r < 6) return (t < sp) ? t + 6'd1 : t - 6'd1;
        if (r < 8) return t;
        if (r == 8) return sp;
        return 6'($urandom);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= ac_next(ac_temp, ac_ideal, mode);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign ac_out_temp = pipe[LAT-1];

    // Run-level model: a run samples once every LAT+1 cycles until it ends.
    logic       e_busy, e_done, e_to, e_fault;
    logic [5:0] e_temp, e_ideal, e_final;
    logic [7:0] e_step;
    int         m_stall, m_cnt;

    always @(posedge clk or negedge rst_n) begin : model
        int stp;
        if (!rst_n) begin
            e_busy <= 0; e_done <= 0; e_to <= 0; e_fault <= 0;
            e_temp <= '0; e_ideal <= '0; e_final <= '0; e_step <= '0;
            m_stall <= 0; m_cnt <= 0;
        end else begin
            e_done <= 0; e_to <= 0; e_fault <= 0;
            if (e_busy) begin
                if (m_cnt > 1) begin
                    m_cnt <= m_cnt - 1;
                end else begin
                    stp = (e_step < 255) ? int'(e_step) + 1 : 255;
                    e_step  <= 8'(stp);
                    e_final <= ac_out_temp;
                    if (ac_out_temp == e_ideal) begin
                        e_busy <= 0; e_done <= 1;
                    end else if (ac_out_temp == e_temp && m_stall + 1 == int'(STALL)) begin
                        e_busy <= 0; e_fault <= 1;
                    end else if (stp == int'(MAXS)) begin
                        e_busy <= 0; e_to <= 1;
                    end else begin
                        e_temp  <= ac_out_temp;
                        m_stall <= (ac_out_temp == e_temp) ? m_stall + 1 : 0;
                        m_cnt   <= LAT + 1;
                    end
                end
            end else if (!(e_done || e_to || e_fault) && start) begin
                e_temp <= room_temp; e_ideal <= ideal; e_step <= '0; m_stall <= 0;
                if (room_temp == ideal) begin
                    e_done <= 1; e_final <= room_temp;
                end else begin
                    e_final <= '0; e_busy <= 1; m_cnt <= LAT + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("timeout", 32'(timeout), 32'(e_to));
            check("fault", 32'(fault), 32'(e_fault));
            check("ac_temp", 32'(ac_temp), 32'(e_temp));
            check("ac_ideal", 32'(ac_ideal), 32'(e_ideal));
            check("step_count", 32'(step_count), 32'(e_step));
            check("final_temp", 32'(final_temp), 32'(e_final));
            check("one_hot_pulse", 32'(done + timeout + fault <= 2'd1), 32'd1);
        end
    end

    task automatic all_zero(input string name);
        check({name, "_outs"}, {ac_temp, ac_ideal, final_temp, step_count, busy, done, timeout, fault}, 32'd0);
    endtask

    task automatic kick(input logic [5:0] r, input logic [5:0] i, input int m);
        @(negedge clk);
        mode = m; room_temp = r; ideal = i; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // kind: 1 done, 2 timeout, 4 fault
    task automatic finish_case(input string name, input int kind, input int stp, input int fin);
        int n = 0;
        while (!(done || timeout || fault) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_bound actual=no_pulse required=pulse within 300 cycles", name);
        end
        check({name, "_kind"}, {29'd0, fault, timeout, done}, 32'(kind));
        check({name, "_step"}, 32'(step_count), 32'(stp));
        check({name, "_final"}, 32'(final_temp), 32'(fin));
    endtask

    initial begin
        #3;
        all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        kick(17, 27, 0);
        finish_case("walk_up", 1, 10, 27);

        kick(30, 30, 0);
        check("equal_busy", 32'(busy), 32'd0);
        finish_case("equal", 1, 0, 30);

        kick(20, 25, 1);
        finish_case("stall", 4, 3, 20);

        kick(10, 40, 0);
        finish_case("timeout", 2, MAXS, 10 + MAXS);

        kick(62, 1, 0);
        finish_case("wrap", 1, 3, 1);

        kick(17, 27, 0);
        repeat (3) @(negedge clk);
        room_temp = 50; ideal = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_case("busy_start", 1, 10, 27);

        kick(40, 50, 0);
        #2 rst_n = 1'b0;
        #1 all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        kick(5, 8, 0);
        finish_case("after_reset", 1, 3, 8);

        mode = 2;
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            room_temp = 6'($urandom);
            ideal = ($urandom_range(0, 1) == 0) ? room_temp + 6'($urandom_range(0, 6)) : 6'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ac_loop_controller.md
Name: ac_loop_controller

Overview:
Closed-loop driver for the AirConditioning block: the initiator side of its temp/ideal -> out_temp interface. On start it latches a room temperature and setpoint, presents them to the AC, and feeds each returned out_temp back as the next temp until the AC reaches the setpoint. It then reports the outcome:
- completion and step count,
- timeout, or
- stall fault.

It replaces the hand-stepped feedback loop used at bench level and sits between the room sensor interface and the AirConditioning instance.

Parameters:
- AC_LATENCY, 1, clk cycles from ac_temp change to valid ac_out_temp (1..4).
- MAX_STEPS, 64, feedback iterations before timeout (1..255).
- STALL_LIMIT, 3, consecutive no-progress samples before fault (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- room_temp  input  6  initial temperature, unsigned 0..63.
- ideal  input  6  setpoint, unsigned 0..63.
- ac_out_temp  input  6  out_temp returned by AirConditioning.
- ac_temp  output  6  temp driven to AirConditioning.
- ac_ideal  output  6  ideal driven to AirConditioning.
- busy  output  1  high from the cycle after accepted start until a terminal state.
- done  output  1  one-cycle pulse: setpoint reached.
- timeout  output  1  one-cycle pulse: MAX_STEPS exhausted.
- fault  output  1  one-cycle pulse: stall detected.
- step_count  output  8  feedback iterations of the last/current run.
- final_temp  output  6  last ac_out_temp sampled; held until the next start.

Behaviour:
- Reset (async, rst_n low): state IDLE, all outputs 0.
- States: IDLE, WAIT, SAMPLE, DONE, TIMEOUT, FAULT. All outputs are registered.
- IDLE, start=1:
  - Latch ac_temp<=room_temp, ac_ideal<=ideal; clear step_count, stall counter and final_temp.
  - If room_temp==ideal, go to DONE (step_count=0, final_temp=room_temp).
  - Otherwise go to WAIT with wait counter = AC_LATENCY-1.
- start while busy, or in a terminal state: ignored.
- WAIT: decrement the wait counter each cycle; at 0 go to SAMPLE.
  - With AC_LATENCY=1, SAMPLE follows on the next cycle.
- SAMPLE (one cycle): final_temp<=ac_out_temp; step_count<=step_count+1, saturating at 255. Then evaluate in priority order:
  1. ac_out_temp==ac_ideal -> DONE.
  2. ac_out_temp==ac_temp (no progress): stall counter +1; if it reaches STALL_LIMIT -> FAULT.
  3. Incremented step_count==MAX_STEPS -> TIMEOUT.
  4. Otherwise ac_temp<=ac_out_temp, clear stall counter if progress was made, reload the wait counter, go to WAIT.
- DONE / TIMEOUT / FAULT: assert the matching pulse for exactly one cycle, busy=0, return to IDLE next cycle.
  - ac_temp, ac_ideal, step_count and final_temp hold their values until the next accepted start.
- busy: 1 in WAIT and SAMPLE; 0 otherwise.
- At most one of done/timeout/fault is high in any cycle.
- Wrap-around: no temperature arithmetic is performed; values are passed through unmodified, so 0 and 63 are legal.
- Reset mid-run: returns to IDLE immediately with all outputs 0; no pulse is emitted.
- Inputs room_temp and ideal are only sampled on accepted start; later changes do not affect a run in progress.

Test Plan:
- room_temp=17, ideal=27, AC steps +1 per cycle, AC_LATENCY=1 -> busy high, ac_temp walks 17..26, done pulse with step_count=10, final_temp=27.
- room_temp=30, ideal=30 -> done pulse on the cycle after start, step_count=0, busy never asserted.
- AC model frozen (out_temp=temp), room_temp=20, ideal=25, STALL_LIMIT=3 -> fault pulse after 3 samples, step_count=3, final_temp=20.
- MAX_STEPS=4, room_temp=10, ideal=40, AC +1 per cycle -> timeout pulse, step_count=4, final_temp=14.
- Second start pulsed while busy, plus room_temp changed mid-run -> ignored; run completes with the original values.
- rst_n driven low during WAIT -> all outputs 0 immediately; a subsequent start with room_temp=5, ideal=8 completes with step_count=3.
